// File: rtl/cpu_handshake_tx.sv
// CPU-side transmit stage: queues core writes in a small FIFO and drives each word to the
// peripheral over a 4-phase send/ack link, with ack synchronisation, timeout/retry and status.
module cpu_handshake_tx #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_err,
  output logic              full,
  output logic              empty,
  output logic              cpu_send,
  output logic [DATA_W-1:0] cpu_dados,
  input  logic              cpu_ack,
  output logic              busy,
  output logic              timeout_err,
  output logic              overflow,
  output logic [7:0]        words_sent
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSend, StRelease, StAbort} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                send_q, send_d;
  logic [DATA_W-1:0]   dados_q, dados_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [7:0]          words_q, words_d;
  logic                terr_q, terr_d;
  logic                ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                ack_s;
  logic                push, pop, timeout_hit;

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;

  assign cpu_send    = send_q;
  assign cpu_dados   = dados_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = terr_q;
  assign overflow    = ovf_q;
  assign words_sent  = words_q;

  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TimerLast);

  // Handshake FSM; cpu_send and cpu_dados are registered outputs of this process.
  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    dados_d = dados_q;
    timer_d = timer_q;
    words_d = words_q;
    terr_d  = clr_err ? 1'b0 : terr_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StSend;
          send_d  = 1'b1;
          dados_d = mem_q[rd_ptr_q];
          timer_d = '0;
        end
      end
      StSend: begin
        if (ack_s) begin
          state_d = StRelease;
          send_d  = 1'b0;
          pop     = 1'b1;
          words_d = words_q + 8'd1;
        end else if (timeout_hit) begin
          state_d = StAbort;
          send_d  = 1'b0;
          terr_d  = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StRelease, StAbort: begin
        if (!ack_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
    ovf_d = clr_err ? 1'b0 : ovf_q;
    if (wr_en && full) ovf_d = 1'b1;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      send_q   <= 1'b0;
      dados_q  <= '0;
      timer_q  <= '0;
      words_q  <= '0;
      terr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      send_q   <= send_d;
      dados_q  <= dados_d;
      timer_q  <= timer_d;
      words_q  <= words_d;
      terr_q   <= terr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= cpu_ack;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge cpu_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_cpu_handshake_tx.sv
// Self-checking bench for cpu_handshake_tx: peripheral model plus a scoreboard of queued words
// checked as each handshake is accepted.
module tb_cpu_handshake_tx;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_data = '0;
  logic       clr_err = 1'b0;
  logic       full, empty, cpu_send, busy, timeout_err, overflow;
  logic [3:0] cpu_dados;
  logic       cpu_ack = 1'b0;
  logic [7:0] words_sent;

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  logic [3:0] exp_q[$];
  logic       auto_ack = 1'b0;
  logic       force_ack = 1'b0;
  logic       prev_send = 1'b0;
  logic       acked = 1'b0;
  logic [3:0] held = '0;
  logic [3:0] exp_w;
  int         ack_low_cnt = 100;

  cpu_handshake_tx #(
    .DATA_W(4), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(8)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .wr_en(wr_en), .wr_data(wr_data),
    .clr_err(clr_err), .full(full), .empty(empty), .cpu_send(cpu_send),
    .cpu_dados(cpu_dados), .cpu_ack(cpu_ack), .busy(busy), .timeout_err(timeout_err),
    .overflow(overflow), .words_sent(words_sent)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Peripheral model and scoreboard: samples on the falling edge, then updates cpu_ack.
  always @(negedge cpu_clk) begin
    if (!cpu_rst) begin
      prev_send = 1'b0;
      acked = 1'b0;
      ack_low_cnt = 100;
      cpu_ack = force_ack;
    end else begin
      if (prev_send && cpu_send && cpu_dados !== held) begin
        errors++;
        $display("FAIL dados_stable: got %0h expected %0h", cpu_dados, held);
      end
      if (cpu_send && cpu_ack) acked = 1'b1;
      if (prev_send && !cpu_send && acked) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %0h expected none", held);
        end else begin
          exp_w = exp_q.pop_front();
          if (held !== exp_w) begin
            errors++;
            $display("FAIL sb_data: got %0h expected %0h", held, exp_w);
          end
        end
        accepted++;
      end
      if (!prev_send && cpu_send) begin
        checks++;
        if (ack_low_cnt < 2) begin
          errors++;
          $display("FAIL send_rerise: ack low for %0d cycles, required >= 2", ack_low_cnt);
        end
        held = cpu_dados;
        acked = 1'b0;
      end
      ack_low_cnt = cpu_ack ? 0 : ack_low_cnt + 1;
      prev_send = cpu_send;
      cpu_ack = auto_ack ? cpu_send : force_ack;
    end
  end

  task automatic tick;
    @(negedge cpu_clk);
    #1;
  endtask

  task automatic do_reset;
    cpu_rst = 1'b0;
    wr_en = 1'b0;
    clr_err = 1'b0;
    auto_ack = 1'b0;
    force_ack = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    accepted = 0;
    cpu_rst = 1'b1;
    tick();
  endtask

  task automatic wait_accepted(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (accepted >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (cpu_send !== 1'b0) begin
        errors++;
        $display("FAIL release_send: got %b expected 0", cpu_send);
      end
      tick();
    end
  endtask

  task automatic test_reset;
    cpu_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'($urandom);
      wr_data = 4'($urandom);
      clr_err = 1'($urandom);
      force_ack = 1'($urandom);
      tick();
    end
    checks++;
    if ({cpu_send, cpu_dados, busy, empty, full, timeout_err, overflow, words_sent} !==
        {1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: got send=%b dados=%0h busy=%b empty=%b full=%b terr=%b ovf=%b ws=%0d expected 0,0,0,1,0,0,0,0",
               cpu_send, cpu_dados, busy, empty, full, timeout_err, overflow, words_sent);
    end
    do_reset();
    wr_en = 1'b1;
    wr_data = 4'h7;
    tick();
    wr_en = 1'b0;
    repeat (3) tick();
    checks++;
    if (cpu_send !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_send: got %b expected 1", cpu_send);
    end
    #2;
    cpu_rst = 1'b0;
    #1;
    checks++;
    if ({cpu_send, busy, empty} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_send: got send=%b busy=%b empty=%b expected 0,0,1",
               cpu_send, busy, empty);
    end
  endtask

  task automatic test_single;
    bit ok;
    do_reset();
    auto_ack = 1'b1;
    wr_en = 1'b1;
    wr_data = 4'hA;
    exp_q.push_back(4'hA);
    tick();
    wr_en = 1'b0;
    checks++;
    if ({cpu_send, empty} !== 2'b00) begin
      errors++;
      $display("FAIL single_c1: got send=%b empty=%b expected 0,0", cpu_send, empty);
    end
    tick();
    checks++;
    if ({cpu_send, cpu_dados, busy} !== {1'b1, 4'hA, 1'b1}) begin
      errors++;
      $display("FAIL single_c2: got send=%b dados=%0h busy=%b expected 1,a,1",
               cpu_send, cpu_dados, busy);
    end
    wait_accepted(1, ok);
    checks++;
    if (!ok || words_sent !== 8'd1) begin
      errors++;
      $display("FAIL single_accept: got ok=%b words_sent=%0d expected 1,1", ok, words_sent);
    end
    tick();
    checks++;
    if ({cpu_send, busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_release: got send=%b busy=%b expected 0,1", cpu_send, busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || empty !== 1'b1 || words_sent !== 8'd1) begin
      errors++;
      $display("FAIL single_end: got ok=%b empty=%b ws=%0d expected 1,1,1", ok, empty, words_sent);
    end
  endtask

  task automatic test_burst;
    bit ok;
    logic [3:0] words [3];
    words[0] = 4'h3;
    words[1] = 4'h5;
    words[2] = 4'h9;
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = words[i];
      exp_q.push_back(words[i]);
      tick();
    end
    wr_en = 1'b0;
    wait_accepted(3, ok);
    wait_idle(ok);
    checks++;
    if (!ok || words_sent !== 8'd3 || empty !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_end: got ok=%b ws=%0d empty=%b left=%0d expected 1,3,1,0",
               ok, words_sent, empty, exp_q.size());
    end
  endtask

  task automatic test_overflow;
    bit ok;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL ovf_not_full3: got %b expected 0", full);
        end
      end
      wr_en = 1'b1;
      wr_data = 4'(i);
      exp_q.push_back(4'(i));
      tick();
    end
    checks++;
    if ({full, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_full4: got full=%b ovf=%b expected 1,0", full, overflow);
    end
    wr_data = 4'h5;
    tick();
    wr_en = 1'b0;
    checks++;
    if ({full, overflow} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_set: got full=%b ovf=%b expected 1,1", full, overflow);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    auto_ack = 1'b1;
    wait_accepted(4, ok);
    wait_idle(ok);
    checks++;
    if (!ok || words_sent !== 8'd4 || empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: got ok=%b ws=%0d empty=%b expected 1,4,1", ok, words_sent, empty);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int hi;
    do_reset();
    wr_en = 1'b1;
    wr_data = 4'h6;
    exp_q.push_back(4'h6);
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 10 && !cpu_send; i++) tick();
    hi = 0;
    for (int i = 0; i < 50 && cpu_send; i++) begin
      hi++;
      tick();
    end
    checks++;
    if (hi != 8) begin
      errors++;
      $display("FAIL timeout_len: got %0d cycles expected 8", hi);
    end
    checks++;
    if ({timeout_err, empty, words_sent} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL timeout_flags: got terr=%b empty=%b ws=%0d expected 1,0,0",
               timeout_err, empty, words_sent);
    end
    auto_ack = 1'b1;
    wait_accepted(1, ok);
    wait_idle(ok);
    checks++;
    if (!ok || words_sent !== 8'd1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL timeout_retry: got ok=%b ws=%0d empty=%b expected 1,1,1", ok, words_sent, empty);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int g = 0; g < 100 && full; g++) tick();
      wr_en = 1'b1;
      wr_data = 4'(i);
      exp_q.push_back(4'(i));
      tick();
      wr_en = 1'b0;
    end
    wait_accepted(300, ok);
    wait_idle(ok);
    checks++;
    if (!ok || words_sent !== 8'd44 || empty !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_end: got ok=%b ws=%0d empty=%b left=%0d expected 1,44,1,0",
               ok, words_sent, empty, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
